// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and sizes for the truth-table sweep checker.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package tt_sweep_checker_pkg;

    localparam int N_VECT = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Bundle between the sweep checker and the two function implementations.
// Wires only, no latency.
// start is a level request; results are held stable while done is set.
interface tt_sweep_checker_if import tt_sweep_checker_pkg::*; ();

    logic               start;
    logic               x;
    logic               y;
    logic               w;
    logic               z;
    logic               s1;
    logic               s2;
    logic               busy;
    logic               done;
    logic [N_VECT-1:0]  mask1;
    logic [N_VECT-1:0]  mask2;
    logic [CNT_W-1:0]   mismatch_count;
    logic               any_mismatch;
    logic [IDX_W-1:0]   first_mismatch;

    // Stimulus/response side: drives start and the two responses.
    modport master (
        output start, s1, s2,
        input  x, y, w, z, busy, done, mask1, mask2,
               mismatch_count, any_mismatch, first_mismatch
    );

    // Checker side.
    modport slave (
        input  start, s1, s2,
        output x, y, w, z, busy, done, mask1, mask2,
               mismatch_count, any_mismatch, first_mismatch
    );

endinterface

// File: rtl/tt_vector_counter.sv
// Minterm index plus per-vector settle counter for the sweep checker.
// Registered outputs, one edge from control to new count.
// No handshake; clear > inc > tick in priority, reset above all.
module tt_vector_counter import tt_sweep_checker_pkg::*; #(
    parameter int SETTLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             tick,
    output logic [IDX_W-1:0] idx,
    output logic             settle_done,
    output logic             last
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [SW-1:0] settle;

    // Index advances once per vector; settle restarts for every new vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx    <= '0;
            settle <= '0;
        end else if (clear) begin
            idx    <= '0;
            settle <= '0;
        end else if (inc) begin
            idx    <= idx + IDX_W'(1);
            settle <= '0;
        end else if (tick) begin
            settle <= settle + SW'(1);
        end
    end

    assign settle_done = (settle == SW'(SETTLE - 1));
    assign last        = (idx == IDX_W'(N_VECT - 1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 minterms into two implementations and compares responses.
// done rises 16*(SETTLE+1) edges after the edge that accepts start.
// start is honoured only in IDLE/DONE; requests while busy are dropped.
module tt_sweep_checker import tt_sweep_checker_pkg::*; #(
    parameter int SETTLE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    tt_sweep_checker_if.slave    bus
);

    state_t             state;
    logic               busy_r;
    logic               done_r;
    logic [N_VECT-1:0]  mask1_r;
    logic [N_VECT-1:0]  mask2_r;
    logic [CNT_W-1:0]   count_r;
    logic               any_r;
    logic [IDX_W-1:0]   first_r;

    logic [IDX_W-1:0]   idx;
    logic               settle_done;
    logic               last;
    logic               cnt_clear;
    logic               cnt_inc;
    logic               cnt_tick;

    // Counter controls decoded from the registered state.
    assign cnt_clear = bus.start && ((state == IDLE) || (state == DONE));
    assign cnt_inc   = (state == SAMPLE) && !last;
    assign cnt_tick  = (state == DRIVE) && !settle_done;

    tt_vector_counter #(.SETTLE(SETTLE)) u_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (cnt_clear),
        .inc         (cnt_inc),
        .tick        (cnt_tick),
        .idx         (idx),
        .settle_done (settle_done),
        .last        (last)
    );

    // Sweep FSM and result registers; s1/s2 are only looked at in SAMPLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mask1_r <= '0;
            mask2_r <= '0;
            count_r <= '0;
            any_r   <= 1'b0;
            first_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mask1_r <= '0;
                        mask2_r <= '0;
                        count_r <= '0;
                        any_r   <= 1'b0;
                        first_r <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_done) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    mask1_r[idx] <= bus.s1;
                    mask2_r[idx] <= bus.s2;
                    if (bus.s1 != bus.s2) begin
                        count_r <= count_r + CNT_W'(1);
                        if (!any_r) begin
                            first_r <= idx;
                            any_r   <= 1'b1;
                        end
                    end
                    if (last) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state  <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Vector bits come straight from the registered index.
    assign bus.x              = idx[3];
    assign bus.y              = idx[2];
    assign bus.w              = idx[1];
    assign bus.z              = idx[0];
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.mask1          = mask1_r;
    assign bus.mask2          = mask2_r;
    assign bus.mismatch_count = count_r;
    assign bus.any_mismatch   = any_r;
    assign bus.first_mismatch = first_r;

endmodule
